// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Alarm sequencer for the watch chip. Holds the alarm setpoint,
//               compares it against the current time and runs the
//               arm / ring / snooze / stop sequence. Drives the buzzer and
//               the armed / ringing / snoozed status flags.
//               Optional feature macro: ALARM_LIGHT_FLASH_EN adds the
//               flash_light output, which toggles on every tick_1s rising
//               edge while ringing.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [5:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    input  logic       inc_m,
    input  logic       dec_m,
    input  logic       inc_h,
    input  logic       dec_h,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic [5:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic       armed,
    output logic       ringing,
    output logic       snoozed,
    output logic       buzzer
`ifdef ALARM_LIGHT_FLASH_EN
    ,
    output logic       flash_light
`endif
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    localparam logic [6:0] c_snooze_min = 7'(SNOOZE_MIN);
    localparam logic [7:0] c_timeout    = 8'(RING_TIMEOUT_S);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       tick_q;
    logic       tick_rise;
    logic [5:0] snz_h;
    logic [5:0] snz_m;
    logic       fired;
    logic [7:0] ring_cnt;
    logic [5:0] trig_h;
    logic [5:0] trig_m;
    logic       match;
    logic       enter_ring;
    logic       enter_snooze;
    logic [6:0] snz_sum;
    logic [5:0] snz_m_calc;
    logic [5:0] snz_h_calc;

    // Edge detect on the slow seconds clock so each second counts once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= tick_1s;
    end

    assign tick_rise = tick_1s & ~tick_q;

    // In SNOOZE the compare target is the snooze time, otherwise the setpoint
    assign trig_h = (state == ST_SNOOZE) ? snz_h : alarm_h;
    assign trig_m = (state == ST_SNOOZE) ? snz_m : alarm_m;

    assign match = (cur_h == trig_h) && (cur_m == trig_m) &&
                   (cur_s == 6'd0) && !fired;

    // Snooze target = now + SNOOZE_MIN with minute carry into a 24 h hour
    always_comb begin
        snz_sum    = {1'b0, cur_m} + c_snooze_min;
        snz_m_calc = snz_sum[5:0];
        snz_h_calc = cur_h;
        if (snz_sum >= 7'd60) begin
            snz_m_calc = 6'(snz_sum - 7'd60);
            snz_h_calc = (cur_h >= 6'd23) ? 6'd0 : cur_h + 6'd1;
        end
    end

    // Next-state logic; stop outranks arm, which outranks snooze
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!btn_stop && btn_arm) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (btn_stop)      state_nxt = ST_ARMED;
                else if (btn_arm)  state_nxt = ST_IDLE;
                else if (match)    state_nxt = ST_RINGING;
            end
            ST_RINGING: begin
                if (btn_stop || btn_arm)        state_nxt = ST_ARMED;
                else if (btn_snooze)            state_nxt = ST_SNOOZE;
                else if (ring_cnt == c_timeout) state_nxt = ST_ARMED;
            end
            ST_SNOOZE: begin
                if (btn_stop)      state_nxt = ST_ARMED;
                else if (btn_arm)  state_nxt = ST_IDLE;
                else if (match)    state_nxt = ST_RINGING;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_ring   = (state != ST_RINGING) && (state_nxt == ST_RINGING);
    assign enter_snooze = (state == ST_RINGING) && (state_nxt == ST_SNOOZE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Seconds of unanswered ringing; restarts on every entry to RINGING
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    ring_cnt <= 8'd0;
        else if (enter_ring)                        ring_cnt <= 8'd0;
        else if (state == ST_RINGING && tick_rise)  ring_cnt <= ring_cnt + 8'd1;
    end

    // One trigger per matching minute: armed again once the minute moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    fired <= 1'b0;
        else if (enter_ring)        fired <= 1'b1;
        else if (cur_m != trig_m)   fired <= 1'b0;
    end

    // Snooze target captured only when snooze is pressed; edits leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snz_h <= 6'd0;
            snz_m <= 6'd0;
        end else if (enter_snooze) begin
            snz_h <= snz_h_calc;
            snz_m <= snz_m_calc;
        end
    end

    // Setpoint minute: wraps 59<->0 without touching the hour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_m <= 6'd0;
        end else if (inc_m && !dec_m) begin
            alarm_m <= (alarm_m >= 6'd59) ? 6'd0 : alarm_m + 6'd1;
        end else if (dec_m && !inc_m) begin
            alarm_m <= (alarm_m == 6'd0) ? 6'd59 : alarm_m - 6'd1;
        end
    end

    // Setpoint hour: wraps 23<->0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_h <= 6'd0;
        end else if (inc_h && !dec_h) begin
            alarm_h <= (alarm_h >= 6'd23) ? 6'd0 : alarm_h + 6'd1;
        end else if (dec_h && !inc_h) begin
            alarm_h <= (alarm_h == 6'd0) ? 6'd23 : alarm_h - 6'd1;
        end
    end

`ifdef ALARM_LIGHT_FLASH_EN
    // Light toggles each second while ringing, held low otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash_light <= 1'b0;
        else if (state == ST_RINGING && state_nxt == ST_RINGING) begin
            if (tick_rise) flash_light <= ~flash_light;
        end else
            flash_light <= 1'b0;
    end
`endif

    assign armed   = (state != ST_IDLE);
    assign ringing = (state == ST_RINGING);
    assign snoozed = (state == ST_SNOOZE);
    assign buzzer  = ringing & tick_1s;

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Directed self-checking bench for alarm_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

    localparam logic [6:0] B_INCM = 7'd1;
    localparam logic [6:0] B_DECM = 7'd2;
    localparam logic [6:0] B_INCH = 7'd4;
    localparam logic [6:0] B_DECH = 7'd8;
    localparam logic [6:0] B_ARM  = 7'd16;
    localparam logic [6:0] B_SNZ  = 7'd32;
    localparam logic [6:0] B_STOP = 7'd64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1s = 1'b0;
    logic [5:0] cur_h = 6'd0;
    logic [5:0] cur_m = 6'd0;
    logic [5:0] cur_s = 6'd0;
    logic       inc_m = 1'b0;
    logic       dec_m = 1'b0;
    logic       inc_h = 1'b0;
    logic       dec_h = 1'b0;
    logic       btn_arm = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       btn_stop = 1'b0;
    logic [5:0] alarm_h;
    logic [5:0] alarm_m;
    logic       armed;
    logic       ringing;
    logic       snoozed;
    logic       buzzer;
`ifdef ALARM_LIGHT_FLASH_EN
    logic       flash_light;
`endif

    int compared = 0;
    int mismatched = 0;

    alarm_controller #(.SNOOZE_MIN(5), .RING_TIMEOUT_S(60)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1s    (tick_1s),
        .cur_h      (cur_h),
        .cur_m      (cur_m),
        .cur_s      (cur_s),
        .inc_m      (inc_m),
        .dec_m      (dec_m),
        .inc_h      (inc_h),
        .dec_h      (dec_h),
        .btn_arm    (btn_arm),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .alarm_h    (alarm_h),
        .alarm_m    (alarm_m),
        .armed      (armed),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .buzzer     (buzzer)
`ifdef ALARM_LIGHT_FLASH_EN
        ,
        .flash_light(flash_light)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] mask, input int times);
        for (int i = 0; i < times; i++) begin
            inc_m = mask[0]; dec_m = mask[1]; inc_h = mask[2]; dec_h = mask[3];
            btn_arm = mask[4]; btn_snooze = mask[5]; btn_stop = mask[6];
            cyc();
            inc_m = 0; dec_m = 0; inc_h = 0; dec_h = 0;
            btn_arm = 0; btn_snooze = 0; btn_stop = 0;
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        cur_h = 6'(h); cur_m = 6'(m); cur_s = 6'(s);
        cyc();
    endtask

    task automatic tick_pulse();
        tick_1s = 1'b1; cyc(); cyc();
        tick_1s = 1'b0; cyc(); cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        compared++;
        if ({alarm_h, alarm_m} !== 12'd0) begin
            $display("FAIL reset_setpoint: got %0d:%0d expected 0:0", alarm_h, alarm_m); mismatched++;
        end
        compared++;
        if ({armed, ringing, snoozed, buzzer} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", {armed, ringing, snoozed, buzzer}); mismatched++;
        end
        rst = 1'b0;
        // Time 00:00:00 matches the 0:00 setpoint but IDLE must ignore it
        set_time(0, 0, 0);
        cyc();
        compared++;
        if (ringing !== 1'b0 || armed !== 1'b0) begin
            $display("FAIL idle_ignores_match: got ringing=%b armed=%b expected 0 0", ringing, armed); mismatched++;
        end
    endtask

    task automatic test_ring_basic();
        set_time(12, 0, 10);
        press(B_INCH, 7);
        press(B_INCM, 30);
        compared++;
        if (alarm_h !== 6'd7 || alarm_m !== 6'd30) begin
            $display("FAIL setpoint_0730: got %0d:%0d expected 7:30", alarm_h, alarm_m); mismatched++;
        end
        press(B_ARM, 1);
        compared++;
        if (armed !== 1'b1) begin
            $display("FAIL arm: got %b expected 1", armed); mismatched++;
        end
        set_time(7, 29, 59);
        compared++;
        if (ringing !== 1'b0) begin
            $display("FAIL early_ring: got %b expected 0", ringing); mismatched++;
        end
        set_time(7, 30, 0);
        compared++;
        if (ringing !== 1'b1 || buzzer !== 1'b0) begin
            $display("FAIL ring_0730: got ringing=%b buzzer=%b expected 1 0", ringing, buzzer); mismatched++;
        end
        tick_1s = 1'b1;
        #1;
        compared++;
        if (buzzer !== 1'b1) begin
            $display("FAIL buzzer_on: got %b expected 1", buzzer); mismatched++;
        end
        tick_1s = 1'b0;
        #1;
        compared++;
        if (buzzer !== 1'b0) begin
            $display("FAIL buzzer_off: got %b expected 0", buzzer); mismatched++;
        end
        set_time(7, 30, 5);
        press(B_STOP, 1);
        compared++;
        if (armed !== 1'b1 || ringing !== 1'b0) begin
            $display("FAIL stop_basic: got armed=%b ringing=%b expected 1 0", armed, ringing); mismatched++;
        end
        set_time(7, 31, 0);
    endtask

    task automatic test_snooze_wrap();
        press(B_DECH, 8);   // 7 -> 23
        press(B_DECM, 32);  // 30 -> 58
        compared++;
        if (alarm_h !== 6'd23 || alarm_m !== 6'd58) begin
            $display("FAIL setpoint_2358: got %0d:%0d expected 23:58", alarm_h, alarm_m); mismatched++;
        end
        set_time(23, 57, 30);
        set_time(23, 58, 0);
        compared++;
        if (ringing !== 1'b1) begin
            $display("FAIL ring_2358: got %b expected 1", ringing); mismatched++;
        end
        set_time(23, 58, 5);
        press(B_SNZ, 1);
        compared++;
        if (snoozed !== 1'b1 || ringing !== 1'b0 || armed !== 1'b1) begin
            $display("FAIL snooze_enter: got snoozed=%b ringing=%b armed=%b expected 1 0 1", snoozed, ringing, armed); mismatched++;
        end
        set_time(23, 59, 0);
        cyc();
        compared++;
        if (ringing !== 1'b0 || snoozed !== 1'b1) begin
            $display("FAIL no_ring_2359: got ringing=%b snoozed=%b expected 0 1", ringing, snoozed); mismatched++;
        end
        set_time(0, 2, 59);
        compared++;
        if (ringing !== 1'b0) begin
            $display("FAIL early_snooze_ring: got %b expected 0", ringing); mismatched++;
        end
        set_time(0, 3, 0);
        compared++;
        if (ringing !== 1'b1 || snoozed !== 1'b0) begin
            $display("FAIL ring_0003: got ringing=%b snoozed=%b expected 1 0", ringing, snoozed); mismatched++;
        end
        press(B_STOP, 1);
        compared++;
        if (armed !== 1'b1 || ringing !== 1'b0 || snoozed !== 1'b0) begin
            $display("FAIL stop_after_snooze: got armed=%b ringing=%b snoozed=%b expected 1 0 0", armed, ringing, snoozed); mismatched++;
        end
    endtask

    task automatic test_timeout();
        press(B_INCH, 8);   // 23 -> 7
        press(B_INCM, 32);  // 58 -> 30
        set_time(7, 29, 0);
        set_time(7, 30, 0);
        compared++;
        if (ringing !== 1'b1) begin
            $display("FAIL timeout_ring_start: got %b expected 1", ringing); mismatched++;
        end
        for (int i = 1; i < 60; i++) begin
            cur_s = 6'(i);
            tick_pulse();
        end
        compared++;
        if (ringing !== 1'b1) begin
            $display("FAIL ring_after_59_ticks: got %b expected 1", ringing); mismatched++;
        end
        tick_1s = 1'b1;
        cyc();
        cyc();
        compared++;
        if (ringing !== 1'b0 || armed !== 1'b1) begin
            $display("FAIL auto_stop_tick60: got ringing=%b armed=%b expected 0 1", ringing, armed); mismatched++;
        end
        tick_1s = 1'b0;
        set_time(7, 30, 0);
        cyc();
        compared++;
        if (ringing !== 1'b0) begin
            $display("FAIL no_retrigger_same_minute: got %b expected 0", ringing); mismatched++;
        end
        set_time(7, 31, 0);
        set_time(7, 30, 0);
        compared++;
        if (ringing !== 1'b1) begin
            $display("FAIL retrigger_next_day: got %b expected 1", ringing); mismatched++;
        end
    endtask

    task automatic test_button_priority();
        press(B_STOP | B_ARM | B_SNZ, 1);
        compared++;
        if (armed !== 1'b1 || ringing !== 1'b0 || snoozed !== 1'b0) begin
            $display("FAIL priority: got armed=%b ringing=%b snoozed=%b expected 1 0 0", armed, ringing, snoozed); mismatched++;
        end
    endtask

    task automatic test_edit_wrap();
        press(B_INCM, 29);  // 30 -> 59
        press(B_INCM, 1);
        compared++;
        if (alarm_m !== 6'd0 || alarm_h !== 6'd7) begin
            $display("FAIL min_wrap_up: got %0d:%0d expected 7:0", alarm_h, alarm_m); mismatched++;
        end
        press(B_DECH, 7);
        press(B_DECH, 1);
        compared++;
        if (alarm_h !== 6'd23) begin
            $display("FAIL hour_wrap_down: got %0d expected 23", alarm_h); mismatched++;
        end
        press(B_INCM | B_DECM | B_INCH | B_DECH, 1);
        compared++;
        if (alarm_h !== 6'd23 || alarm_m !== 6'd0) begin
            $display("FAIL inc_dec_cancel: got %0d:%0d expected 23:0", alarm_h, alarm_m); mismatched++;
        end
        press(B_INCM | B_INCH, 1);
        compared++;
        if (alarm_h !== 6'd0 || alarm_m !== 6'd1 || armed !== 1'b1) begin
            $display("FAIL min_hour_both: got %0d:%0d armed=%b expected 0:1 1", alarm_h, alarm_m, armed); mismatched++;
        end
    endtask

    task automatic test_reset_mid_ring();
        set_time(0, 0, 30);
        set_time(0, 1, 0);
        compared++;
        if (ringing !== 1'b1) begin
            $display("FAIL ring_0001: got %b expected 1", ringing); mismatched++;
        end
        tick_pulse();
        tick_pulse();
        tick_pulse();
`ifdef ALARM_LIGHT_FLASH_EN
        compared++;
        if (flash_light !== 1'b1) begin
            $display("FAIL flash_3_toggles: got %b expected 1", flash_light); mismatched++;
        end
`endif
        tick_1s = 1'b1;
        @(posedge clk);
        #3;
        compared++;
        if (buzzer !== 1'b1) begin
            $display("FAIL buzzer_before_rst: got %b expected 1", buzzer); mismatched++;
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({ringing, buzzer, armed} !== 3'b000 || {alarm_h, alarm_m} !== 12'd0) begin
            $display("FAIL async_rst: got r=%b b=%b a=%b sp=%0d:%0d expected 0 0 0 0:0",
                     ringing, buzzer, armed, alarm_h, alarm_m); mismatched++;
        end
`ifdef ALARM_LIGHT_FLASH_EN
        compared++;
        if (flash_light !== 1'b0) begin
            $display("FAIL flash_rst: got %b expected 0", flash_light); mismatched++;
        end
`endif
        tick_1s = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_ring_basic();
        test_snooze_wrap();
        test_timeout();
        test_button_priority();
        test_edit_wrap();
        test_reset_mid_ring();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
